// File: rtl/folded_fir_mac.sv
// Folded FIR core: one multiplier and one accumulator walk the TAPS taps
// serially, producing one exact, full-precision result per accepted sample.
module folded_fir_mac #(
    parameter int TAPS = 8,
    parameter int DW = 10,
    parameter int CW = 10,
    localparam int AW = DW + CW + $clog2(TAPS),
    localparam int KW = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          coef_we,
    input  logic [KW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    output logic [AW-1:0] out_data
);

    typedef enum logic {IDLE, MAC} state_t;

    state_t state;
    state_t state_next;

    logic        [KW-1:0]    k;
    logic signed [AW-1:0]    acc;
    logic signed [DW-1:0]    x [TAPS];
    logic signed [CW-1:0]    c [TAPS];
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    prod_ext;

    assign prod     = (DW+CW)'(x[k]) * (DW+CW)'(c[k]);
    assign prod_ext = AW'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k == KW'(TAPS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Coefficient writes and sample shifts only happen while idle, so the
    // taps seen by an in-flight MAC pass never change underneath it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        c[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x[i] <= x[i-1];
                        end
                        x[0] <= in_data;
                        acc  <= '0;
                        k    <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + KW'(1);
                    if (k == KW'(TAPS - 1)) begin
                        out_data  <= acc + prod_ext;
                        out_valid <= 1'b1;
                        k         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_folded_fir_mac.sv
// Self-checking bench for folded_fir_mac: a sum-of-products reference model
// checked every cycle, plus hand-computed directed expectations.
module tb_folded_fir_mac;

    localparam int TAPS = 8;
    localparam int DW = 10;
    localparam int CW = 10;
    localparam int AW = DW + CW + $clog2(TAPS);
    localparam int KW = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          coef_we;
    logic [KW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          out_valid;
    logic [AW-1:0] out_data;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int     m_hist [TAPS];
    int     m_coef [TAPS];
    int     m_busy;
    longint m_pending;
    bit     exp_in_ready;
    bit     exp_out_valid;
    longint exp_out_data;

    always #5 clk = ~clk;

    folded_fir_mac #(.TAPS(TAPS), .DW(DW), .CW(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .out_data(out_data)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: a result is the plain dot product of the last TAPS
    // accepted samples with the coefficients, delivered TAPS edges later.
    initial begin
        m_busy = 0;
        m_pending = 0;
        exp_in_ready = 1'b1;
        exp_out_valid = 1'b0;
        exp_out_data = 0;
        for (int i = 0; i < TAPS; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 0;
        end
        forever begin
            @(posedge clk);
            exp_out_valid = 1'b0;
            if (!rst_n) begin
                m_busy = 0;
                exp_out_data = 0;
                for (int i = 0; i < TAPS; i++) begin
                    m_hist[i] = 0;
                    m_coef[i] = 0;
                end
            end else if (m_busy == 0) begin
                if (coef_we) m_coef[coef_addr] = int'($signed(coef_data));
                if (in_valid) begin
                    for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                    m_hist[0] = int'($signed(in_data));
                    m_pending = 0;
                    for (int i = 0; i < TAPS; i++)
                        m_pending += longint'(m_coef[i]) * longint'(m_hist[i]);
                    m_busy = TAPS;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    exp_out_valid = 1'b1;
                    exp_out_data = m_pending;
                end
            end
            exp_in_ready = (m_busy == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("in_ready", longint'(in_ready), longint'(exp_in_ready));
                checkOutput("out_valid", longint'(out_valid), longint'(exp_out_valid));
                checkOutput("out_data", longint'($signed(out_data)), exp_out_data);
            end
        end
    end

    task automatic waitIdle();
        int guard = 0;
        while (!exp_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: waited %0d cycles, required under 50", guard);
        end
    endtask

    task automatic writeCoef(input int addr, input int data);
        coef_we = 1'b1;
        coef_addr = addr[KW-1:0];
        coef_data = data[CW-1:0];
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic loadAll(input int data);
        waitIdle();
        for (int i = 0; i < TAPS; i++) writeCoef(i, data);
    endtask

    task automatic applyStimulus(input int sample, input bit we, input int addr, input int data);
        waitIdle();
        in_valid = 1'b1;
        in_data = sample[DW-1:0];
        coef_we = we;
        coef_addr = addr[KW-1:0];
        coef_data = data[CW-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic waitResult(output longint val, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL result_timeout: no out_valid after %0d cycles, required 8", cycles);
        end
        val = longint'($signed(out_data));
    endtask

    task automatic feedAndCheck(input string name, input int sample, input longint expected);
        longint v;
        int cyc;
        applyStimulus(sample, 1'b0, 0, 0);
        waitResult(v, cyc);
        checkOutput(name, v, expected);
        checkOutput({name, "_latency"}, longint'(cyc), 8);
    endtask

    task automatic feedOnly(input int sample, output longint v);
        int cyc;
        applyStimulus(sample, 1'b0, 0, 0);
        waitResult(v, cyc);
    endtask

    initial begin
        int pat [8] = '{511, -75, 256, -436, 0, -436, 256, -75};
        longint v;
        int rc;
        int vc;
        logic [31:0] r;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_in_ready", longint'(in_ready), 1);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_data", longint'($signed(out_data)), 0);
        rst_n = 1'b1;

        // Impulse response through coefficients 1..8
        loadAll(0);
        for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
        feedAndCheck("impulse", 1, 1);
        for (int i = 1; i <= TAPS; i++) feedAndCheck("impulse", 0, (i < TAPS) ? i + 1 : 0);

        // Throughput with in_valid held high: ready 1 of every 9 cycles
        @(negedge clk);
        rc = 0;
        vc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            r = $urandom;
            in_data = r[DW-1:0];
            rc += int'(in_ready);
            vc += int'(out_valid);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("throughput_ready_cycles", longint'(rc), 5);
        checkOutput("throughput_out_pulses", longint'(vc), 4);

        // Streamer pattern with unit coefficients sums to 1 once primed
        loadAll(1);
        for (int n = 0; n < 16; n++) begin
            feedOnly(pat[n % 8], v);
            if (n >= 7) checkOutput("streamer", v, 1);
        end

        // Extreme operands must not wrap
        loadAll(-512);
        for (int n = 0; n < 8; n++) feedOnly(-512, v);
        checkOutput("extreme_neg_neg", v, 2097152);
        loadAll(511);
        for (int n = 0; n < 8; n++) feedOnly(-512, v);
        checkOutput("extreme_pos_neg", v, -2093056);

        // Coefficient write during MAC is dropped; in IDLE it applies at once
        waitIdle();
        for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
        for (int n = 0; n < 8; n++) feedOnly(0, v);
        applyStimulus(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        writeCoef(3, 100);
        waitResult(v, rc);
        checkOutput("mac_write_y0", v, 1);
        feedAndCheck("mac_write_y1", 0, 2);
        feedAndCheck("mac_write_y2", 0, 3);
        feedAndCheck("mac_write_ignored", 0, 4);
        for (int n = 0; n < 8; n++) feedOnly(0, v);
        feedAndCheck("idle_write_y0", 1, 1);
        feedAndCheck("idle_write_y1", 0, 2);
        feedAndCheck("idle_write_y2", 0, 3);
        applyStimulus(0, 1'b1, 3, 100);
        waitResult(v, rc);
        checkOutput("idle_write_applied", v, 100);

        // Reset mid-MAC discards the result and clears coefficients
        applyStimulus(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midmac_reset_in_ready", longint'(in_ready), 1);
        vc = 0;
        for (int i = 0; i < 12; i++) begin
            vc += int'(out_valid);
            @(negedge clk);
        end
        checkOutput("midmac_reset_no_output", longint'(vc), 0);
        feedAndCheck("post_reset_impulse", 1, 0);
        for (int i = 1; i <= TAPS; i++) feedAndCheck("post_reset_impulse", 0, 0);

        // Randomized traffic, coefficient writes and occasional resets
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = $urandom;
            in_valid = r[0];
            coef_we = (r[2:1] == 2'b00);
            rst_n = (r[9:3] != 7'd0);
            r = $urandom;
            in_data = r[DW-1:0];
            coef_addr = r[DW+KW-1:DW];
            r = $urandom;
            coef_data = r[CW-1:0];
            @(negedge clk);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
